fetch_unit: RTL

Instruction-fetch stage of the five-stage pipeline; owns the PC/nPC pair and the IF/ID pipeline register. It presents the PC to instruction memory, captures the returned word into IF/ID, and advances by MIPS delayed-branch semantics: the instruction after a taken branch or jump (the delay slot) always executes. It takes stall and redirect inputs from the ID stage and feeds the control unit and the ID/EX stage downstream.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_if.sv | 25 ++
 rtl/fetch_pc_pair.sv | 54 +++++
 rtl/fetch_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HOLD      = 2'd1,
        HOLD_PEND = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Branch/jump targets are word addresses; the low two bits are discarded.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory port, ID-stage controls and IF/ID outputs.
interface fetch_if #(
    parameter int IMEM_AW = 9
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_data;
    logic               stall;
    logic               redirect;
    logic [31:0]        redirect_target;
    logic [31:0]        pc;
    logic [31:0]        npc;
    logic [31:0]        ifid_instr;
    logic [31:0]        ifid_pc;
    logic               ifid_valid;

    modport master (
        output imem_addr, pc, npc, ifid_instr, ifid_pc, ifid_valid,
        input  imem_data, stall, redirect, redirect_target
    );

    modport slave (
        input  imem_addr, pc, npc, ifid_instr, ifid_pc, ifid_valid,
        output imem_data, stall, redirect, redirect_target
    );
endinterface

// File: rtl/fetch_pc_pair.sv
// PC/nPC register pair with delayed-branch update: pc always takes nPC, nPC
// takes either nPC+4 or the branch target.
module fetch_pc_pair
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        load_target,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] npc
);

    localparam logic [31:0] RESET_NPC = RESET_PC + 32'd4;

    logic [31:0] pc_r;
    logic [31:0] npc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] npc_nxt_s;

    // Next-state selection: hold, redirect into nPC, or sequential advance.
    always_comb begin
        pc_nxt_s  = pc_r;
        npc_nxt_s = npc_r;
        if (hold) begin
            pc_nxt_s  = pc_r;
            npc_nxt_s = npc_r;
        end else if (load_target) begin
            pc_nxt_s  = npc_r;
            npc_nxt_s = target;
        end else begin
            pc_nxt_s  = npc_r;
            npc_nxt_s = npc_r + 32'd4;
        end
    end

    // PC/nPC state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r  <= RESET_PC;
            npc_r <= RESET_NPC;
        end else begin
            pc_r  <= pc_nxt_s;
            npc_r <= npc_nxt_s;
        end
    end

    assign pc  = pc_r;
    assign npc = npc_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC/nPC pair, stall/redirect FSM and IF/ID register.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          IMEM_AW  = 9
) (
    input  logic        clk,
    input  logic        reset,
    fetch_if.master     bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] fetch_count,
    output logic [15:0] stall_count
`endif
);

    fetch_state_e state_r;
    logic [31:0]  pend_tgt_r;
    logic [31:0]  ifid_instr_r;
    logic [31:0]  ifid_pc_r;
    logic         ifid_valid_r;

    logic [31:0]  live_tgt_s;
    logic [31:0]  redirect_tgt_s;
    logic         take_redirect_s;
    logic [31:0]  pc_s;
    logic [31:0]  npc_s;

    // A redirect that arrived during a stall is replayed on release unless a
    // fresh redirect on the release edge supersedes it.
    always_comb begin
        live_tgt_s      = align_word(bus.redirect_target);
        take_redirect_s = 1'b0;
        redirect_tgt_s  = pend_tgt_r;
        if (bus.stall) begin
            take_redirect_s = 1'b0;
            redirect_tgt_s  = pend_tgt_r;
        end else if (bus.redirect) begin
            take_redirect_s = 1'b1;
            redirect_tgt_s  = live_tgt_s;
        end else if (state_r == HOLD_PEND) begin
            take_redirect_s = 1'b1;
            redirect_tgt_s  = pend_tgt_r;
        end else begin
            take_redirect_s = 1'b0;
            redirect_tgt_s  = pend_tgt_r;
        end
    end

    fetch_pc_pair #(
        .RESET_PC (RESET_PC)
    ) u_pc_pair (
        .clk         (clk),
        .reset       (reset),
        .hold        (bus.stall),
        .load_target (take_redirect_s),
        .target      (redirect_tgt_s),
        .pc          (pc_s),
        .npc         (npc_s)
    );

    // Stall/redirect FSM and pending-target latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= RUN;
            pend_tgt_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                RUN, HOLD: begin
                    if (bus.stall && bus.redirect) begin
                        pend_tgt_r <= live_tgt_s;
                        state_r    <= HOLD_PEND;
                    end else if (bus.stall) begin
                        state_r    <= HOLD;
                    end else begin
                        state_r    <= RUN;
                    end
                end
                HOLD_PEND: begin
                    if (bus.stall && bus.redirect) begin
                        pend_tgt_r <= live_tgt_s;
                        state_r    <= HOLD_PEND;
                    end else if (bus.stall) begin
                        state_r    <= HOLD_PEND;
                    end else begin
                        pend_tgt_r <= 32'h0000_0000;
                        state_r    <= RUN;
                    end
                end
                default: begin
                    pend_tgt_r <= 32'h0000_0000;
                    state_r    <= RUN;
                end
            endcase
        end
    end

    // IF/ID pipeline register; the delay slot is captured like any other fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifid_instr_r <= NOP;
            ifid_pc_r    <= 32'h0000_0000;
            ifid_valid_r <= 1'b0;
        end else if (!bus.stall) begin
            ifid_instr_r <= bus.imem_data;
            ifid_pc_r    <= pc_s;
            ifid_valid_r <= 1'b1;
        end else begin
            ifid_instr_r <= ifid_instr_r;
            ifid_pc_r    <= ifid_pc_r;
            ifid_valid_r <= ifid_valid_r;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count_r;
    logic [15:0] stall_count_r;

    // Saturating fetch and stall event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_r <= 16'h0000;
            stall_count_r <= 16'h0000;
        end else if (bus.stall) begin
            if (stall_count_r != 16'hFFFF) begin
                stall_count_r <= stall_count_r + 16'd1;
            end else begin
                stall_count_r <= stall_count_r;
            end
        end else begin
            if (fetch_count_r != 16'hFFFF) begin
                fetch_count_r <= fetch_count_r + 16'd1;
            end else begin
                fetch_count_r <= fetch_count_r;
            end
        end
    end

    assign fetch_count = fetch_count_r;
    assign stall_count = stall_count_r;
`endif

    assign bus.imem_addr  = pc_s[IMEM_AW-1:0];
    assign bus.pc         = pc_s;
    assign bus.npc        = npc_s;
    assign bus.ifid_instr = ifid_instr_r;
    assign bus.ifid_pc    = ifid_pc_r;
    assign bus.ifid_valid = ifid_valid_r;

endmodule
